data_mem_responder: RTL and testbench

// - Responder end of the core's load/store interface: serves word reads and byte-masked writes

---
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake,
// with programmable wait states and an error response for bad addresses.
module data_mem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
   input  logic        i_clk,
   input  logic        i_srst_n,
   input  logic        i_reqValid,
   output logic        o_reqReady,
   input  logic        i_reqWrite,
   input  logic [31:0] i_reqAddress,
   input  logic [31:0] i_reqWriteData,
   input  logic [3:0]  i_reqByteEn,
   output logic        o_rspValid,
   input  logic        i_rspReady,
   output logic [31:0] o_rspReadData,
   output logic        o_rspError
);

   localparam int          IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

   stateT             stateReg, stateNext;
   logic [3:0]        waitCntReg, waitCntNext;
   logic              writeReg;
   logic [31:0]       addrReg;
   logic [31:0]       wdataReg;
   logic [3:0]        byteEnReg;
   logic              rspValidReg;
   logic [31:0]       rspDataReg;
   logic              rspErrorReg;
   logic              accept, commit, rspDone;
   logic              addrErr;
   logic              memWe;
   logic [IDX_W-1:0]  wordIdx;
   logic [31:0]       mem [DEPTH_WORDS];

   // Range check on the full address so out-of-window accesses never alias.
   always_comb begin
      addrErr = (addrReg[1:0] != 2'b00) || (addrReg < BASE_ADDR) ||
                ((addrReg - BASE_ADDR) >= SPAN);
      wordIdx = IDX_W'((addrReg - BASE_ADDR) >> 2);
   end

   assign o_reqReady    = i_srst_n && (stateReg == IDLE);
   assign o_rspValid    = rspValidReg;
   assign o_rspReadData = rspDataReg;
   assign o_rspError    = rspErrorReg;
   assign memWe         = commit && writeReg && !addrErr && i_srst_n;

   // WAIT always spans WAIT_STATES+1 cycles: the first is the decode cycle,
   // giving a response WAIT_STATES+1 cycles after accept.
   always_comb begin
      stateNext   = stateReg;
      waitCntNext = waitCntReg;
      accept      = 1'b0;
      commit      = 1'b0;
      rspDone     = 1'b0;
      case (stateReg)
         IDLE: begin
            if (i_reqValid && o_reqReady) begin
               accept      = 1'b1;
               stateNext   = WAIT;
               waitCntNext = 4'd0;
            end
         end
         WAIT: begin
            if (waitCntReg == WAIT_LAST) begin
               commit      = 1'b1;
               stateNext   = RESP;
               waitCntNext = 4'd0;
            end else begin
               waitCntNext = waitCntReg + 4'd1;
            end
         end
         RESP: begin
            if (i_rspReady) begin
               rspDone   = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         stateReg    <= IDLE;
         waitCntReg  <= 4'd0;
         rspValidReg <= 1'b0;
         rspDataReg  <= 32'd0;
         rspErrorReg <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         waitCntReg <= waitCntNext;
         if (accept) begin
            writeReg  <= i_reqWrite;
            addrReg   <= i_reqAddress;
            wdataReg  <= i_reqWriteData;
            byteEnReg <= i_reqByteEn;
         end
         if (commit) begin
            rspValidReg <= 1'b1;
            rspErrorReg <= addrErr;
            rspDataReg  <= (!writeReg && !addrErr) ? mem[wordIdx] : 32'd0;
         end else if (rspDone) begin
            rspValidReg <= 1'b0;
            rspErrorReg <= 1'b0;
            rspDataReg  <= 32'd0;
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (memWe) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEnReg[b]) mem[wordIdx][8*b +: 8] <= wdataReg[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked every
// cycle against a cycle-count transaction model, plus directed literal checks.
module tb_data_mem_responder;

   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int          DEPTH = 256;

   logic        clk = 1'b0;
   logic        rstN;
   logic        reqValid [2];
   logic        reqReady [2];
   logic        reqWrite [2];
   logic [31:0] reqAddress [2];
   logic [31:0] reqWriteData [2];
   logic [3:0]  reqByteEn [2];
   logic        rspValid [2];
   logic        rspReady [2];
   logic [31:0] rspReadData [2];
   logic        rspError [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE)) dutWs2 (
      .i_clk(clk), .i_srst_n(rstN),
      .i_reqValid(reqValid[0]), .o_reqReady(reqReady[0]), .i_reqWrite(reqWrite[0]),
      .i_reqAddress(reqAddress[0]), .i_reqWriteData(reqWriteData[0]), .i_reqByteEn(reqByteEn[0]),
      .o_rspValid(rspValid[0]), .i_rspReady(rspReady[0]),
      .o_rspReadData(rspReadData[0]), .o_rspError(rspError[0])
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dutWs0 (
      .i_clk(clk), .i_srst_n(rstN),
      .i_reqValid(reqValid[1]), .o_reqReady(reqReady[1]), .i_reqWrite(reqWrite[1]),
      .i_reqAddress(reqAddress[1]), .i_reqWriteData(reqWriteData[1]), .i_reqByteEn(reqByteEn[1]),
      .o_rspValid(rspValid[1]), .i_rspReady(rspReady[1]),
      .o_rspReadData(rspReadData[1]), .o_rspError(rspError[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- transaction model ----------------
   bit          mBusy [2];
   bit          mDone [2];
   int          mAcc [2];
   logic        mWr [2];
   logic [31:0] mAddr [2];
   logic [31:0] mWd [2];
   logic [3:0]  mBe [2];
   logic [31:0] mRd [2];
   logic        mErr [2];
   logic [31:0] mMem [2][DEPTH];

   function automatic int wsOf(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic bit addrBad(input logic [31:0] a);
      longint unsigned la;
      la = longint'(a);
      return (a[1:0] != 2'b00) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH);
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         mBusy[d] = 1'b0;
         mDone[d] = 1'b0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         if (!rstN) begin
            started = 1'b1;
            for (int d = 0; d < 2; d++) begin
               mBusy[d] = 1'b0;
               mDone[d] = 1'b0;
            end
         end else begin
            for (int d = 0; d < 2; d++) begin
               if (mBusy[d]) begin
                  if (mDone[d]) begin
                     if (rspReady[d]) begin
                        mBusy[d] = 1'b0;
                        mDone[d] = 1'b0;
                     end
                  end else if (cyc == mAcc[d] + 1 + wsOf(d)) begin
                     int idx;
                     mDone[d] = 1'b1;
                     mErr[d]  = addrBad(mAddr[d]);
                     mRd[d]   = 32'd0;
                     if (!mErr[d]) begin
                        idx = int'((mAddr[d] - BASE) / 4);
                        if (mWr[d]) begin
                           for (int k = 0; k < 4; k++)
                              if (mBe[d][k]) mMem[d][idx][8*k +: 8] = mWd[d][8*k +: 8];
                        end else begin
                           mRd[d] = mMem[d][idx];
                        end
                     end
                  end
               end else if (reqValid[d]) begin
                  mBusy[d] = 1'b1;
                  mAcc[d]  = cyc;
                  mWr[d]   = reqWrite[d];
                  mAddr[d] = reqAddress[d];
                  mWd[d]   = reqWriteData[d];
                  mBe[d]   = reqByteEn[d];
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            for (int d = 0; d < 2; d++) begin
               logic expV;
               expV = mBusy[d] && mDone[d];
               check($sformatf("d%0d reqReady", d), 32'(reqReady[d]), 32'(rstN && !mBusy[d]));
               check($sformatf("d%0d rspValid", d), 32'(rspValid[d]), 32'(expV));
               check($sformatf("d%0d rspReadData", d), rspReadData[d], expV ? mRd[d] : 32'd0);
               check($sformatf("d%0d rspError", d), 32'(rspError[d]), 32'(expV && mErr[d]));
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       input logic [31:0] expData, input logic expErr, input string name);
      int t;
      int acc;
      rspReady[d]     = 1'b0;
      reqValid[d]     = 1'b1;
      reqWrite[d]     = wr;
      reqAddress[d]   = addr;
      reqWriteData[d] = wdata;
      reqByteEn[d]    = be;
      t = 0;
      while (!reqReady[d] && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 50) check({name, " accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      acc = cyc;
      reqValid[d]     = 1'b0;
      reqWrite[d]     = ~wr;
      reqAddress[d]   = 32'hFFFF_FFFF;
      reqWriteData[d] = ~wdata;
      reqByteEn[d]    = ~be;
      t = 0;
      while (!rspValid[d] && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 50) check({name, " rsp_timeout"}, 32'd0, 32'd1);
      check({name, " latency"}, 32'(cyc - acc), (d == 0) ? 32'd3 : 32'd1);
      check({name, " data"}, rspReadData[d], expData);
      check({name, " error"}, 32'(rspError[d]), 32'(expErr));
      repeat (hold) begin
         @(posedge clk); #1;
      end
      rspReady[d] = 1'b1;
      @(posedge clk); #1;
      rspReady[d] = 1'b0;
      check({name, " ready_after_rsp"}, 32'(reqReady[d]), 32'd1);
      $display("xfer %s: d%0d %s addr=%h wdata=%h be=%b -> data=%h err=%0d",
               name, d, wr ? "ST" : "LD", addr, wdata, be, rspReadData[d], rspError[d]);
   endtask

   initial begin
      logic [31:0] b2bAddr [3];
      logic [31:0] b2bData [3];
      int          prevAcc;
      int          acc;
      int          t;
      b2bAddr = '{32'h2010, 32'h2014, 32'h2018};
      b2bData = '{32'h1010_1010, 32'h2020_2020, 32'h3030_3030};
      rstN = 1'b0;
      for (int d = 0; d < 2; d++) begin
         reqValid[d] = 1'b0; reqWrite[d] = 1'b0; reqAddress[d] = 32'd0;
         reqWriteData[d] = 32'd0; reqByteEn[d] = 4'd0; rspReady[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset reqReady", 32'(reqReady[0]), 32'd0);
      check("reset rspValid", 32'(rspValid[0]), 32'd0);
      rstN = 1'b1;
      @(posedge clk); #1;

      xfer(0, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'hF, 0, 32'd0, 1'b0, "st_full");
      xfer(0, 1'b0, 32'h2004, 32'd0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, "ld_full");
      xfer(0, 1'b1, 32'h2004, 32'h0000_00AA, 4'b0001, 0, 32'd0, 1'b0, "st_lane0");
      xfer(0, 1'b0, 32'h2004, 32'd0, 4'hF, 0, 32'hDEAD_BEAA, 1'b0, "ld_merged");
      xfer(0, 1'b0, 32'h2002, 32'd0, 4'hF, 0, 32'd0, 1'b1, "ld_misaligned");
      xfer(0, 1'b0, 32'h1FFC, 32'd0, 4'hF, 0, 32'd0, 1'b1, "ld_below");
      xfer(0, 1'b0, 32'h2400, 32'd0, 4'hF, 0, 32'd0, 1'b1, "ld_above");
      xfer(0, 1'b1, 32'h2000, 32'h0102_0304, 4'hF, 0, 32'd0, 1'b0, "st_word0");
      xfer(0, 1'b1, 32'h2400, 32'hFFFF_FFFF, 4'hF, 0, 32'd0, 1'b1, "st_above");
      xfer(0, 1'b0, 32'h2000, 32'd0, 4'hF, 0, 32'h0102_0304, 1'b0, "ld_no_alias");
      xfer(0, 1'b1, 32'h2004, 32'h1234_5678, 4'b0000, 0, 32'd0, 1'b0, "st_no_lanes");
      xfer(0, 1'b0, 32'h2004, 32'd0, 4'hF, 5, 32'hDEAD_BEAA, 1'b0, "ld_hold5");
      xfer(0, 1'b1, 32'h23FC, 32'hCAFE_F00D, 4'hF, 0, 32'd0, 1'b0, "st_last");
      xfer(0, 1'b0, 32'h23FC, 32'd0, 4'hF, 0, 32'hCAFE_F00D, 1'b0, "ld_last");
      xfer(0, 1'b1, 32'h2008, 32'h1122_3344, 4'hF, 0, 32'd0, 1'b0, "st_2008");

      // Reset while a store sits in WAIT: the store must not land.
      reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqAddress[0] = 32'h2008;
      reqWriteData[0] = 32'h5566_7788; reqByteEn[0] = 4'hF;
      @(posedge clk); #1;
      reqValid[0] = 1'b0;
      rstN = 1'b0;
      @(posedge clk); #1;
      check("rst_wait reqReady", 32'(reqReady[0]), 32'd0);
      check("rst_wait rspValid", 32'(rspValid[0]), 32'd0);
      check("rst_wait rspReadData", rspReadData[0], 32'd0);
      check("rst_wait rspError", 32'(rspError[0]), 32'd0);
      @(posedge clk); #1;
      rstN = 1'b1;
      @(posedge clk); #1;
      $display("xfer rst_in_wait: d0 ST addr=00002008 dropped by reset");
      xfer(0, 1'b0, 32'h2008, 32'd0, 4'hF, 0, 32'h1122_3344, 1'b0, "ld_after_rst");

      // Zero wait states: preload, then back-to-back loads with valid held high.
      for (int i = 0; i < 3; i++)
         xfer(1, 1'b1, b2bAddr[i], b2bData[i], 4'hF, 0, 32'd0, 1'b0, "ws0_st");
      rspReady[1] = 1'b1;
      reqValid[1] = 1'b1; reqWrite[1] = 1'b0; reqAddress[1] = b2bAddr[0];
      reqByteEn[1] = 4'h0;
      prevAcc = 0;
      for (int i = 0; i < 3; i++) begin
         t = 0;
         while (!reqReady[1] && t < 50) begin
            @(posedge clk); #1; t++;
         end
         if (t >= 50) check("b2b accept_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
         acc = cyc;
         if (i > 0) check("b2b accept_spacing", 32'(acc - prevAcc), 32'd3);
         prevAcc = acc;
         if (i < 2) reqAddress[1] = b2bAddr[i+1];
         else reqValid[1] = 1'b0;
         @(posedge clk); #1;
         check("b2b rspValid", 32'(rspValid[1]), 32'd1);
         check("b2b data", rspReadData[1], b2bData[i]);
         $display("xfer b2b: d1 LD addr=%h accepted cycle %0d -> data=%h err=%0d",
                  b2bAddr[i], acc, rspReadData[1], rspError[1]);
      end
      repeat (3) @(posedge clk);
      #1;
      rspReady[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
